sumsq_scheduler: RTL and testbench

- Shares one DW x DW squaring multiplier between NCH ADC sample streams using round-robin arbitration.
- Accumulates per-channel sums of squares over a window of 2^WIN_LOG2 samples and emits one energy word per channel per window.
- Sits between the per-channel capture FIFOs and the readout/statistics logic in the DAQ datapath.

---
 rtl/sumsq_pkg.sv | 16 +
 rtl/sumsq_scheduler_square_pipe.sv | 59 +++++
 rtl/sumsq_scheduler.sv | 142 ++++++++++++++
 tb/tb_sumsq_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sumsq_pkg.sv
// Shared constants and width helpers for the sum-of-squares scheduler.
package sumsq_pkg;

    localparam int unsigned DEFAULT_WIN_LOG2 = 10;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Accumulator width: wide enough for a full window of maximum squares.
    function automatic int unsigned acc_w(input int unsigned dw, input int unsigned win_log2);
        return 2 * dw + win_log2;
    endfunction

endpackage

// File: rtl/sumsq_scheduler_square_pipe.sv
// Registered unsigned squarer: an operand register followed by MULT_LAT
// product stages, with a valid/tag sideband carried alongside.
module square_pipe #(
    parameter int unsigned DW       = 10,
    parameter int unsigned TW       = 2,
    parameter int unsigned MULT_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    input  logic [TW-1:0]   in_tag,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    output logic [TW-1:0]   out_tag,
    output logic [2*DW-1:0] out_prod,
    output logic            busy
);

    logic                op_valid_q;
    logic [TW-1:0]       op_tag_q;
    logic [DW-1:0]       op_data_q;
    logic [2*DW-1:0]     op_sq;
    logic [MULT_LAT-1:0] vld_q;
    logic [TW-1:0]       tag_q  [MULT_LAT];
    logic [2*DW-1:0]     prod_q [MULT_LAT];

    // Zero-extend so the product keeps all 2*DW bits.
    assign op_sq = {{DW{1'b0}}, op_data_q} * {{DW{1'b0}}, op_data_q};

    // Valid sideband: flushed by rst or clear so in-flight samples are dropped.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            op_valid_q <= 1'b0;
            vld_q      <= '0;
        end else begin
            op_valid_q <= in_valid;
            for (int i = 0; i < int'(MULT_LAT); i++) begin
                vld_q[i] <= (i == 0) ? op_valid_q : vld_q[i-1];
            end
        end
    end

    // Data path: no reset needed, qualified by the valid sideband.
    always_ff @(posedge clk) begin
        op_tag_q  <= in_tag;
        op_data_q <= in_data;
        for (int i = 0; i < int'(MULT_LAT); i++) begin
            tag_q[i]  <= (i == 0) ? op_tag_q : tag_q[i-1];
            prod_q[i] <= (i == 0) ? op_sq    : prod_q[i-1];
        end
    end

    assign out_valid = vld_q[MULT_LAT-1];
    assign out_tag   = tag_q[MULT_LAT-1];
    assign out_prod  = prod_q[MULT_LAT-1];
    assign busy      = op_valid_q | (|vld_q);

endmodule

// File: rtl/sumsq_scheduler.sv
// Round-robin shares one squarer between NCH sample streams and accumulates
// per-channel windowed sums of squares, emitting one energy word per window.
module sumsq_scheduler
    import sumsq_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned DW       = 10,
    parameter int unsigned WIN_LOG2 = DEFAULT_WIN_LOG2,
    parameter int unsigned MULT_LAT = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                clear,
    input  logic [NCH-1:0]                      s_valid,
    input  logic [NCH*DW-1:0]                   s_data,
    output logic [NCH-1:0]                      s_ready,
    output logic                                e_valid,
    output logic [chan_w(NCH)-1:0]              e_chan,
    output logic [acc_w(DW, WIN_LOG2)-1:0]      e_data,
    output logic                                busy
);

    localparam int unsigned CW = chan_w(NCH);
    localparam int unsigned AW = acc_w(DW, WIN_LOG2);

    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       gnt_idx, idx_c;
    logic                gnt_found, hs;
    logic [DW-1:0]       issue_data;
    logic                r_valid;
    logic [CW-1:0]       r_tag;
    logic [2*DW-1:0]     r_prod;
    logic [AW-1:0]       r_sum;
    logic [AW-1:0]       acc_q [NCH];
    logic [WIN_LOG2-1:0] cnt_q [NCH];
    logic                e_valid_q;
    logic [CW-1:0]       e_chan_q;
    logic [AW-1:0]       e_data_q;

    // Arbiter: first requester at or above the pointer, with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx_c     = '0;
        s_ready   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx_c = CW'((32'(ptr_q) + i) % NCH);
            if (!gnt_found && s_valid[idx_c]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_c;
            end
        end
        if (!rst && !clear && enable && gnt_found) begin
            s_ready[gnt_idx] = 1'b1;
        end
    end

    assign hs = |s_ready;

    // Operand mux for the granted channel.
    always_comb begin
        issue_data = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (gnt_idx == CW'(k)) begin
                issue_data = s_data[k*DW +: DW];
            end
        end
    end

    // Pointer advances past the granted channel only on a handshake.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (hs) begin
            ptr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    square_pipe #(
        .DW       (DW),
        .TW       (CW),
        .MULT_LAT (MULT_LAT)
    ) u_square_pipe (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (hs),
        .in_tag    (gnt_idx),
        .in_data   (issue_data),
        .out_valid (r_valid),
        .out_tag   (r_tag),
        .out_prod  (r_prod),
        .busy      (busy)
    );

    assign r_sum = acc_q[r_tag] + AW'(r_prod);

    // Accumulator bank and output register; clear wins over a retiring sample.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < int'(NCH); k++) begin
                acc_q[k] <= '0;
                cnt_q[k] <= '0;
            end
            e_valid_q <= 1'b0;
            if (rst) begin
                e_chan_q <= '0;
                e_data_q <= '0;
            end
        end else begin
            e_valid_q <= 1'b0;
            if (r_valid) begin
                if (cnt_q[r_tag] == {WIN_LOG2{1'b1}}) begin
                    e_data_q     <= r_sum;
                    e_chan_q     <= r_tag;
                    e_valid_q    <= 1'b1;
                    acc_q[r_tag] <= '0;
                    cnt_q[r_tag] <= '0;
                end else begin
                    acc_q[r_tag] <= r_sum;
                    cnt_q[r_tag] <= cnt_q[r_tag] + WIN_LOG2'(1);
                end
            end
        end
    end

    assign e_valid = e_valid_q;
    assign e_chan  = e_chan_q;
    assign e_data  = e_data_q;

endmodule

// File: tb/tb_sumsq_scheduler.sv
// Directed bench for sumsq_scheduler with a 4-sample window.
module tb_sumsq_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW = 10;
    localparam int unsigned WIN_LOG2 = 2;
    localparam int unsigned MULT_LAT = 2;
    localparam int unsigned AW = 2 * DW + WIN_LOG2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              clear = 1'b0;
    logic [NCH-1:0]    s_valid = '0;
    logic [NCH*DW-1:0] s_data = '0;
    logic [NCH-1:0]    s_ready;
    logic              e_valid;
    logic [1:0]        e_chan;
    logic [AW-1:0]     e_data;
    logic              busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int hs_ch[$];
    int hs_e[$];
    int ev_ch[$];
    int ev_d[$];
    int ev_e[$];

    sumsq_scheduler #(
        .NCH      (NCH),
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .clear   (clear),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .e_valid (e_valid),
        .e_chan  (e_chan),
        .e_data  (e_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log handshakes (edge they occur on) and energy words (edge that set them).
    always @(negedge clk) begin
        for (int k = 0; k < int'(NCH); k++) begin
            if (s_valid[k] && s_ready[k]) begin
                hs_ch.push_back(k);
                hs_e.push_back(cyc + 1);
            end
        end
        if (e_valid) begin
            ev_ch.push_back(int'(e_chan));
            ev_d.push_back(int'(e_data));
            ev_e.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_logs();
        hs_ch.delete(); hs_e.delete();
        ev_ch.delete(); ev_d.delete(); ev_e.delete();
    endtask

    task automatic set_data(input int ch, input int val);
        s_data[ch*DW +: DW] = DW'(val);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; s_valid = '1;
        tick(); tick();
        checks++;
        if (s_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_s_ready: got %b expected 0000", s_ready);
        end
        checks++;
        if ({e_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL reset_valid_busy: got %b expected 00", {e_valid, busy});
        end
        checks++;
        if (e_chan !== 2'd0 || e_data !== '0) begin
            failures++; $display("FAIL reset_outputs: got chan %0d data %0d expected 0 0", e_chan, e_data);
        end
        s_valid = '0; rst = 1'b0;
        tick();
        flush_logs();
    endtask

    task automatic test_single_channel();
        flush_logs();
        set_data(0, 1023);
        s_valid = 4'b0001;
        #1;
        checks++;
        if (s_ready !== 4'b0001) begin
            failures++; $display("FAIL single_grant: got %b expected 0001", s_ready);
        end
        repeat (4) tick();
        s_valid = '0;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL single_busy_high: got %b expected 1", busy);
        end
        repeat (8) tick();
        checks++;
        if (ev_ch.size() !== 1 || hs_e.size() !== 4) begin
            failures++; $display("FAIL single_counts: got ev %0d hs %0d expected 1 4", ev_ch.size(), hs_e.size());
        end else begin
            checks++;
            if (ev_ch[0] !== 0 || ev_d[0] !== 4186116) begin
                failures++; $display("FAIL single_word: got chan %0d data %0d expected 0 4186116", ev_ch[0], ev_d[0]);
            end
            checks++;
            if (ev_e[0] - hs_e[3] !== 3) begin
                failures++; $display("FAIL single_latency: got %0d expected 3", ev_e[0] - hs_e[3]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL single_busy_low: got %b expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        pulse_clear();
        flush_logs();
        for (int k = 0; k < 4; k++) set_data(k, k + 1);
        s_valid = 4'b1111;
        #1;
        checks++;
        if (s_ready !== 4'b0001) begin
            failures++; $display("FAIL rr_first_grant: got %b expected 0001", s_ready);
        end
        repeat (16) tick();
        s_valid = '0;
        repeat (8) tick();
        checks++;
        if (hs_ch.size() !== 16) begin
            failures++; $display("FAIL rr_hs_count: got %0d expected 16", hs_ch.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (hs_ch[i] !== i % 4) begin
                    failures++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, hs_ch[i], i % 4);
                end
            end
        end
        checks++;
        if (ev_ch.size() !== 4) begin
            failures++; $display("FAIL rr_ev_count: got %0d expected 4", ev_ch.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ev_ch[i] !== i || ev_d[i] !== 4 * (i + 1) * (i + 1) || ev_e[i] !== ev_e[0] + i) begin
                    failures++;
                    $display("FAIL rr_word[%0d]: got chan %0d data %0d edge +%0d expected %0d %0d +%0d",
                             i, ev_ch[i], ev_d[i], ev_e[i] - ev_e[0], i, 4 * (i + 1) * (i + 1), i);
                end
            end
        end
    endtask

    task automatic test_sparse_channels();
        int base;
        pulse_clear();
        set_data(1, 1); set_data(3, 1);
        s_valid = 4'b0010;
        tick();                       // grant 1 moves pointer to 2
        flush_logs();
        s_valid = 4'b1010;
        #1;
        checks++;
        if (s_ready !== 4'b1000) begin
            failures++; $display("FAIL sparse_first_grant: got %b expected 1000", s_ready);
        end
        base = hs_ch.size();
        repeat (6) tick();
        s_valid = '0;
        checks++;
        if (hs_ch.size() - base !== 6) begin
            failures++; $display("FAIL sparse_hs_count: got %0d expected 6", hs_ch.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (hs_ch[base + i] !== ((i % 2 == 0) ? 3 : 1)) begin
                    failures++; $display("FAIL sparse_order[%0d]: got %0d expected %0d",
                                         i, hs_ch[base + i], (i % 2 == 0) ? 3 : 1);
                end
            end
        end
        repeat (6) tick();
    endtask

    task automatic test_enable_drop();
        int n;
        bit fell;
        pulse_clear();
        flush_logs();
        set_data(0, 7);
        s_valid = 4'b0001;
        repeat (2) tick();
        enable = 1'b0;
        #1;
        checks++;
        if (s_ready !== 4'b0000 || busy !== 1'b1) begin
            failures++; $display("FAIL en_drop_now: got ready %b busy %b expected 0000 1", s_ready, busy);
        end
        fell = 1'b0;
        n = 0;
        while (!fell && n < 10) begin
            tick();
            n++;
            if (busy === 1'b0) fell = 1'b1;
        end
        checks++;
        if (!fell) begin
            failures++; $display("FAIL en_busy_fall: got busy %b after %0d clocks expected 0", busy, n);
        end
        checks++;
        if (hs_ch.size() !== 2) begin
            failures++; $display("FAIL en_hs_count: got %0d expected 2", hs_ch.size());
        end
        enable = 1'b1;
        repeat (2) tick();
        s_valid = '0;
        repeat (8) tick();
        checks++;
        if (ev_ch.size() !== 1 || ev_d[0] !== 196 || ev_ch[0] !== 0) begin
            failures++; $display("FAIL en_retired_word: got n %0d data %0d expected 1 196",
                                 ev_ch.size(), ev_d[0]);
        end
    endtask

    task automatic test_clear_on_retire();
        pulse_clear();
        flush_logs();
        set_data(2, 100);
        s_valid = 4'b0100;
        repeat (4) tick();            // handshake edges E1..E4
        s_valid = '0;
        repeat (2) tick();
        clear = 1'b1;                 // high on edge E4+3, where sample 4 retires
        tick();
        clear = 1'b0;
        repeat (6) tick();
        checks++;
        if (ev_ch.size() !== 0) begin
            failures++; $display("FAIL clr_no_word: got %0d words expected 0", ev_ch.size());
        end
        set_data(2, 5);
        s_valid = 4'b0100;
        repeat (4) tick();
        s_valid = '0;
        repeat (8) tick();
        checks++;
        if (ev_ch.size() !== 1 || ev_d[0] !== 100 || ev_ch[0] !== 2) begin
            failures++; $display("FAIL clr_next_window: got n %0d chan %0d data %0d expected 1 2 100",
                                 ev_ch.size(), ev_ch[0], ev_d[0]);
        end
    endtask

    task automatic test_reset_mid_window();
        pulse_clear();
        set_data(0, 30); set_data(1, 30);
        s_valid = 4'b0011;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_ready: got %b expected 0000", s_ready);
        end
        repeat (2) tick();
        checks++;
        if (e_valid !== 1'b0 || e_chan !== 2'd0 || e_data !== '0 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_outputs: got v %b chan %0d data %0d busy %b expected all 0",
                                 e_valid, e_chan, e_data, busy);
        end
        s_valid = '0;
        rst = 1'b0;
        tick();
        flush_logs();
        set_data(0, 10);
        s_valid = 4'b0001;
        repeat (4) tick();
        s_valid = '0;
        repeat (8) tick();
        checks++;
        if (ev_ch.size() !== 1 || ev_d[0] !== 400 || ev_ch[0] !== 0) begin
            failures++; $display("FAIL rst_next_window: got n %0d chan %0d data %0d expected 1 0 400",
                                 ev_ch.size(), ev_ch[0], ev_d[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_sparse_channels();
        test_enable_drop();
        test_clear_on_retire();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
